// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// The optional LSU_ALIGN_CHECK_EN build uses misaligned() to reject unaligned half/word accesses.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READ  = 2'b01,
        S_WRITE = 2'b10,
        S_RESP  = 2'b11
    } lsu_state_e;

    localparam int unsigned WORD_BYTES = 4;

    // The reserved size code behaves exactly like a word access.
    function automatic logic is_word(input lsu_size_e size);
        return (size == SZ_W) || (size == SZ_RSV);
    endfunction

    function automatic logic misaligned(input lsu_size_e size, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        if (size == SZ_H && lo[0]) bad = 1'b1;
        if (is_word(size) && lo != 2'b00) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane logic: load extension and read-modify-write merge for sub-word stores.
// Purely combinational; the controller registers whatever it needs.
module lsu_lane
    import lsu_pkg::*;
(
    input  lsu_size_e   size,
    input  logic        uns,
    input  logic [31:0] mem_rd,
    input  logic [31:0] wdata,
    output logic [31:0] load_ext,
    output logic [31:0] store_merge
);

    always_comb begin
        load_ext    = mem_rd;
        store_merge = wdata;
        unique case (size)
            SZ_B: begin
                load_ext    = {{24{~uns & mem_rd[7]}}, mem_rd[7:0]};
                store_merge = {mem_rd[31:8], wdata[7:0]};
            end
            SZ_H: begin
                load_ext    = {{16{~uns & mem_rd[15]}}, mem_rd[15:0]};
                store_merge = {mem_rd[31:16], wdata[15:0]};
            end
            default: begin
                load_ext    = mem_rd;
                store_merge = wdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller in front of a combinational-read, 4-byte-write memory.
// Define LSU_ALIGN_CHECK_EN to reject misaligned half/word accesses in addition to the range check.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_ra,
    input  logic [31:0] mem_rd,
    output logic        mem_we,
    output logic [31:0] mem_wa,
    output logic [31:0] mem_wd,
    output lsu_state_e  dbg_state
);

    // Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and resp_valid is a single-cycle pulse with no backpressure.

    localparam logic [31:0] LAST_WORD = 32'(MEM_SIZE - WORD_BYTES);

    lsu_state_e  state;
    lsu_size_e   size_q;
    lsu_size_e   req_size_e;
    logic        we_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] load_ext;
    logic [31:0] store_merge;
    logic        req_err;

    assign req_size_e = lsu_size_e'(req_size);

    always_comb begin
        req_err = (req_addr > LAST_WORD);
`ifdef LSU_ALIGN_CHECK_EN
        if (misaligned(req_size_e, req_addr[1:0])) req_err = 1'b1;
`else
        req_err = req_err | 1'b0;
`endif
    end

    lsu_lane u_lane (
        .size        (size_q),
        .uns         (uns_q),
        .mem_rd      (mem_rd),
        .wdata       (wdata_q),
        .load_ext    (load_ext),
        .store_merge (store_merge)
    );

    // Decoded from state so an asynchronous reset removes the write strobe immediately.
    assign mem_we    = (state == S_WRITE);
    assign req_ready = (state == S_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= SZ_B;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_ra     <= '0;
            mem_wa     <= '0;
            mem_wd     <= '0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        uns_q      <= req_unsigned;
                        size_q     <= req_size_e;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        resp_rdata <= '0;
                        if (req_err) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_we && is_word(req_size_e)) begin
                            state    <= S_WRITE;
                            mem_wa   <= req_addr;
                            mem_wd   <= req_wdata;
                            resp_err <= 1'b0;
                        end else begin
                            state    <= S_READ;
                            mem_ra   <= req_addr;
                            resp_err <= 1'b0;
                        end
                    end
                end
                S_READ: begin
                    if (we_q) begin
                        // Merge the new sub-word into the freshly read word, then write all 4 bytes.
                        state  <= S_WRITE;
                        mem_wa <= addr_q;
                        mem_wd <= store_merge;
                    end else begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_ext;
                    end
                end
                S_WRITE: begin
                    state      <= S_RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                end
                S_RESP: begin
                    state      <= S_IDLE;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: byte-array memory, reference byte-image model and per-cycle response checker.
module tb_lsu_ctrl;

    localparam int MEM_SIZE = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_ra;
    logic [31:0] mem_rd;
    logic        mem_we;
    logic [31:0] mem_wa;
    logic [31:0] mem_wd;
    logic [1:0]  dbg_state;

    lsu_ctrl #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_ra       (mem_ra),
        .mem_rd       (mem_rd),
        .mem_we       (mem_we),
        .mem_wa       (mem_wa),
        .mem_wd       (mem_wd),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // ---------------- memory seen by the DUT ----------------
    logic [7:0] mem     [0:MEM_SIZE-1];
    logic [7:0] ref_mem [0:MEM_SIZE-1];
    int          wr_total = 0;
    logic [31:0] last_wa = '0;
    logic [31:0] last_wd = '0;

    always_comb begin
        mem_rd = '0;
        if (mem_ra <= 32'(MEM_SIZE - 4))
            mem_rd = {mem[mem_ra[11:0] + 12'd3], mem[mem_ra[11:0] + 12'd2],
                      mem[mem_ra[11:0] + 12'd1], mem[mem_ra[11:0]]};
    end

    always @(posedge clk) begin
        if (mem_we) begin
            wr_total = wr_total + 1;
            last_wa  = mem_wa;
            last_wd  = mem_wd;
            if (mem_wa <= 32'(MEM_SIZE - 4)) begin
                for (int i = 0; i < 4; i++) mem[int'(mem_wa) + i] = mem_wd[8*i +: 8];
            end
        end
    end

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] sz);
        if (sz == 2'b00) return 1;
        if (sz == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
        logic e;
        e = (a > 32'(MEM_SIZE - 4));
`ifdef LSU_ALIGN_CHECK_EN
        if (sz == 2'b01 && a[0]) e = 1'b1;
        if (sz[1] && a[1:0] != 2'b00) e = 1'b1;
`else
        e = e | (sz == 2'b00 && 1'b0);
`endif
        return e;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) v = v + (32'(ref_mem[int'(a) + i]) << (8 * i));
        return v;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
        int          nb;
        logic [31:0] v;
        nb = nbytes(sz);
        v  = '0;
        for (int i = 0; i < nb; i++) v = v + (32'(ref_mem[int'(a) + i]) << (8 * i));
        if (!uns && nb < 4 && v >= (32'd1 << (8 * nb - 1))) v = v - (32'd1 << (8 * nb));
        return v;
    endfunction

    function automatic int image_diffs();
        int d;
        d = 0;
        for (int i = 0; i < MEM_SIZE; i++) if (mem[i] !== ref_mem[i]) d = d + 1;
        return d;
    endfunction

    // ---------------- compare process ----------------
    logic        chk_en = 1'b0;
    logic        exp_pending = 1'b0;
    int          exp_cyc = 0;
    logic [31:0] exp_rdata = '0;
    logic        exp_err = 1'b0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_pending && cyc == exp_cyc) begin
                chk("resp_valid", 32'(resp_valid), 32'd1);
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_err", 32'(resp_err), 32'(exp_err));
                chk("req_ready_resp", 32'(req_ready), 32'd0);
                last_rdata  = resp_rdata;
                last_err    = resp_err;
                exp_pending = 1'b0;
            end else begin
                chk("resp_valid_quiet", 32'(resp_valid), 32'd0);
                chk("req_ready", 32'(req_ready), 32'(!exp_pending));
            end
        end
    end

    // ---------------- driver ----------------
    // Called at a negedge; returns at the negedge of the first IDLE cycle after the response.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd);
        int          lat;
        int          w0;
        int          nb;
        logic        e;
        logic [31:0] r;
        logic [31:0] ewd;
        chk("ready_before_req", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        w0 = wr_total;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        e   = model_err(sz, a);
        nb  = nbytes(sz);
        r   = '0;
        ewd = '0;
        if (e) begin
            lat = 1;
        end else if (!we) begin
            r   = model_load(sz, uns, a);
            lat = 2;
        end else begin
            for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
            ewd = model_word(a);
            lat = (nb == 4) ? 2 : 3;
        end
        exp_rdata   = r;
        exp_err     = e;
        exp_cyc     = cyc + lat - 1;
        exp_pending = 1'b1;
        repeat (lat + 1) @(negedge clk);
        chk("resp_timeout", 32'(exp_pending), 32'd0);
        exp_pending = 1'b0;
        chk("write_count", 32'(wr_total - w0), (we && !e) ? 32'd1 : 32'd0);
        if (we && !e) begin
            chk("write_addr", last_wa, a);
            chk("write_data", last_wd, ewd);
        end
        chk("mem_image", 32'(image_diffs()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w0;
        logic [31:0] ra;
        for (int i = 0; i < MEM_SIZE; i++) begin
            mem[i]     = 8'((i * 7 + 3) % 256);
            ref_mem[i] = 8'((i * 7 + 3) % 256);
        end
        mem[16'h10] = 8'h80; mem[16'h11] = 8'h7F; mem[16'h12] = 8'h01; mem[16'h13] = 8'h02;
        ref_mem[16'h10] = 8'h80; ref_mem[16'h11] = 8'h7F; ref_mem[16'h12] = 8'h01; ref_mem[16'h13] = 8'h02;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_ra", mem_ra, 32'd0);
        chk("rst_mem_wa", mem_wa, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        // Loads with extension
        do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        chk("pin_lb_signed", last_rdata, 32'hFFFFFF80);
        do_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
        chk("pin_lbu", last_rdata, 32'h00000080);
        do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        chk("pin_lh", last_rdata, 32'h00007F80);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("pin_lw", last_rdata, 32'h02017F80);
        do_req(1'b0, 2'b11, 1'b1, 32'h10, 32'h0);

        // Word store, then byte RMW next to it
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF);
        chk("pin_sw_wa", last_wa, 32'h20);
        chk("pin_sw_wd", last_wd, 32'hDEADBEEF);
        do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h00000055);
        chk("pin_sb_wa", last_wa, 32'h21);
        chk("pin_sb_wd", last_wd, 32'hFFDEAD55);
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        chk("pin_lw_after_sb", last_rdata, 32'hDEAD55EF);
        do_req(1'b0, 2'b00, 1'b1, 32'h24, 32'h0);
        chk("pin_byte_24_kept", last_rdata, 32'h000000FF);

        // Half store and readback
        do_req(1'b1, 2'b01, 1'b0, 32'h30, 32'hABCD8001);
        do_req(1'b0, 2'b01, 1'b0, 32'h30, 32'h0);
        chk("pin_lh_after_sh", last_rdata, 32'hFFFF8001);

        // Range boundary
        do_req(1'b0, 2'b10, 1'b0, 32'hFFD, 32'h0);
        chk("pin_range_err", 32'(last_err), 32'd1);
        chk("pin_range_rdata", last_rdata, 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0);
        chk("pin_last_word_ok", 32'(last_err), 32'd0);
        do_req(1'b1, 2'b00, 1'b0, 32'hFFF, 32'h11);
        do_req(1'b1, 2'b10, 1'b0, 32'h1000, 32'h12345678);
        do_req(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0);

        // Unaligned half load
        do_req(1'b0, 2'b01, 1'b0, 32'h41, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
        chk("pin_lh_unaligned_err", 32'(last_err), 32'd1);
`else
        chk("pin_lh_unaligned", last_rdata, 32'hFFFFD1CA);
`endif

        // Reset during the write phase of a half RMW
        chk_en = 1'b0;
        w0 = wr_total;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h00001234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 6 && !mem_we; i++) @(negedge clk);
        chk("rmw_reached_write", 32'(mem_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready_after", 32'(req_ready), 32'd1);
        chk("rst_mid_no_write", 32'(wr_total - w0), 32'd0);
        chk_en = 1'b1;
        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        chk("pin_lw_after_reset", last_rdata, 32'hD8D1CAC3);

        // Mixed traffic over a small window plus the top of memory
        for (int n = 0; n < 24; n++) begin
            ra = (n % 6 == 5) ? 32'($urandom_range(4088, 4100)) : 32'($urandom_range(256, 320));
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ra, $urandom);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
